alu_ctrl_pipe: RTL
==================

ALU_CTRL_PIPE -- requirements
Module: alu_ctrl_pipe

Interface
REQ-001 SHALL have parameter ALUOPW, default 4: ALU control code width, minimum 4; codes zero-extended above bit 3.
REQ-002 SHALL have parameter MD_LAT, default 4: mult/div busy cycles, range 0..15.
REQ-003 SHALL have port clk  in  1  sole clock, rising edge.
REQ-004 SHALL have port rst  in  1  asynchronous, active-high reset.
REQ-005 SHALL have ports in_valid  in  1 and in_ready  out  1: input handshake.
REQ-006 SHALL have ports opcode  in  6 and funct  in  6: instruction bits [31:26] and [5:0].
REQ-007 SHALL have ports out_valid  out  1 and out_ready  in  1: output handshake.
REQ-008 SHALL have port aluop  out  ALUOPW  registered ALU control code.
REQ-009 SHALL have port illegal  out  1  registered, qualifies aluop: unrecognised encoding.
REQ-010 SHALL have port md_busy  out  1  multi-cycle unit occupied.

Function
REQ-011 SHALL use codes ADD=0, SUB=1, AND=2, OR=3, XOR=4, NOR=5, SLT=6, SLTU=7, SLL=8, SRL=9, SRA=10, LUI=11, MULT=12, DIV=13.
REQ-012 SHALL decode opcode 000000 by funct: 100000/100001->ADD, 100010/100011->SUB, 100100->AND, 100101->OR, 100110->XOR, 100111->NOR, 101010->SLT, 101011->SLTU, 000000->SLL, 000010->SRL, 000011->SRA, 011000->MULT, 011010->DIV.
REQ-013 SHALL decode opcodes 001000/001001/100011/101011->ADD, 000100/000101->SUB, 001010->SLT, 001100->AND, 001101->OR, 001110->XOR, 001111->LUI; funct ignored.
REQ-014 SHALL map any other encoding to aluop=ADD with illegal=1; illegal=0 otherwise.
REQ-015 SHALL accept a beat when in_valid and in_ready are high; result appears at out_valid one cycle later (latency 1).
REQ-016 SHALL drive in_ready = (!out_valid | out_ready) & !md_busy, combinationally.
REQ-017 SHALL hold aluop and illegal stable while out_valid=1 and out_ready=0.
REQ-018 SHALL, on accept and drain in the same cycle, load the new beat with out_valid staying 1 (no bubble).
REQ-019 SHALL clear out_valid after drain when no new beat is accepted.
REQ-020 SHALL use md FSM states IDLE and BUSY with a 4-bit down-counter.
REQ-021 SHALL transition IDLE->BUSY when a MULT or DIV beat is accepted and MD_LAT>0, loading counter with MD_LAT.
REQ-022 SHALL decrement the counter each BUSY cycle and return BUSY->IDLE in the cycle after it reaches 1.
REQ-023 SHALL assert md_busy exactly in BUSY, i.e. MD_LAT cycles starting the cycle after acceptance.
REQ-024 SHALL never enter BUSY when MD_LAT=0.

Reset
REQ-025 SHALL, on rst, asynchronously set out_valid=0, aluop=0, illegal=0, md_busy=0, state=IDLE, counter=0.
REQ-026 SHALL abort any BUSY period and discard any held output on rst mid-operation; in_ready=1 in the first cycle after release.

Configuration
REQ-027 SHALL compile mult/div support only when ALU_CTRL_MD_EN is defined.
REQ-028 SHALL, without ALU_CTRL_MD_EN, decode funct 011000/011010 as illegal (ADD, illegal=1), omit FSM and counter, and tie md_busy=0.

Structure
REQ-029 SHALL place ALU code constants, opcode/funct constants and the FSM state typedef in package alu_ctrl_pkg.
REQ-030 SHALL implement the decode table in combinational sub-module alu_ctrl_dec (opcode, funct -> code, illegal); alu_ctrl_pipe holds registers, handshake and FSM.

Verification
REQ-031 SHALL cover opcode 000000, funct 100010, out_ready=1 -> next cycle out_valid=1, aluop=1, illegal=0.
REQ-032 SHALL cover opcode 001111 then opcode 111111 back-to-back -> aluop=11, illegal=0, then aluop=0, illegal=1; no bubble.
REQ-033 SHALL cover out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, aluop held; one beat on release.
REQ-034 SHALL cover MD_EN, MD_LAT=4, funct 011000 accepted -> aluop=12; md_busy=1 and in_ready=0 for exactly 4 cycles, then in_ready=1.
REQ-035 SHALL cover rst pulse in the 2nd BUSY cycle -> all outputs 0 immediately; in_ready=1 after release.
REQ-036 SHALL cover build without MD_EN, funct 011010 -> aluop=0, illegal=1, md_busy stays 0.

Source files
------------

// File: rtl/alu_ctrl_pkg.sv
// Shared constants for the ALU control pipeline: ALU codes, opcode/funct encodings
// and the mult/div occupancy FSM state type.
package alu_ctrl_pkg;

  localparam int unsigned CODE_W   = 4;
  localparam int unsigned FIELD_W  = 6;
  localparam int unsigned MD_CNT_W = 4;

  typedef logic [CODE_W-1:0]  alu_code_t;
  typedef logic [FIELD_W-1:0] field_t;

  localparam alu_code_t ALU_ADD  = 4'd0;
  localparam alu_code_t ALU_SUB  = 4'd1;
  localparam alu_code_t ALU_AND  = 4'd2;
  localparam alu_code_t ALU_OR   = 4'd3;
  localparam alu_code_t ALU_XOR  = 4'd4;
  localparam alu_code_t ALU_NOR  = 4'd5;
  localparam alu_code_t ALU_SLT  = 4'd6;
  localparam alu_code_t ALU_SLTU = 4'd7;
  localparam alu_code_t ALU_SLL  = 4'd8;
  localparam alu_code_t ALU_SRL  = 4'd9;
  localparam alu_code_t ALU_SRA  = 4'd10;
  localparam alu_code_t ALU_LUI  = 4'd11;
  localparam alu_code_t ALU_MULT = 4'd12;
  localparam alu_code_t ALU_DIV  = 4'd13;

  localparam field_t OP_RTYPE = 6'b000000;
  localparam field_t OP_ADDI  = 6'b001000;
  localparam field_t OP_ADDIU = 6'b001001;
  localparam field_t OP_LW    = 6'b100011;
  localparam field_t OP_SW    = 6'b101011;
  localparam field_t OP_BEQ   = 6'b000100;
  localparam field_t OP_BNE   = 6'b000101;
  localparam field_t OP_SLTI  = 6'b001010;
  localparam field_t OP_ANDI  = 6'b001100;
  localparam field_t OP_ORI   = 6'b001101;
  localparam field_t OP_XORI  = 6'b001110;
  localparam field_t OP_LUI   = 6'b001111;

  localparam field_t FN_ADD  = 6'b100000;
  localparam field_t FN_ADDU = 6'b100001;
  localparam field_t FN_SUB  = 6'b100010;
  localparam field_t FN_SUBU = 6'b100011;
  localparam field_t FN_AND  = 6'b100100;
  localparam field_t FN_OR   = 6'b100101;
  localparam field_t FN_XOR  = 6'b100110;
  localparam field_t FN_NOR  = 6'b100111;
  localparam field_t FN_SLT  = 6'b101010;
  localparam field_t FN_SLTU = 6'b101011;
  localparam field_t FN_SLL  = 6'b000000;
  localparam field_t FN_SRL  = 6'b000010;
  localparam field_t FN_SRA  = 6'b000011;
  localparam field_t FN_MULT = 6'b011000;
  localparam field_t FN_DIV  = 6'b011010;

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} md_state_t;

endpackage

// File: rtl/alu_ctrl_dec.sv
// Combinational opcode/funct -> ALU control decode. Mult/div functs decode only when
// ALU_CTRL_MD_EN is defined; otherwise they fall through to illegal.
module alu_ctrl_dec
  import alu_ctrl_pkg::*;
(
  input  logic [FIELD_W-1:0] i_opcode,
  input  logic [FIELD_W-1:0] i_funct,
  output logic [CODE_W-1:0]  o_code,
  output logic               o_illegal
);

  always_comb begin
    o_code    = ALU_ADD;
    o_illegal = 1'b0;
    case (i_opcode)
      OP_RTYPE: begin
        case (i_funct)
          FN_ADD, FN_ADDU: o_code = ALU_ADD;
          FN_SUB, FN_SUBU: o_code = ALU_SUB;
          FN_AND:          o_code = ALU_AND;
          FN_OR:           o_code = ALU_OR;
          FN_XOR:          o_code = ALU_XOR;
          FN_NOR:          o_code = ALU_NOR;
          FN_SLT:          o_code = ALU_SLT;
          FN_SLTU:         o_code = ALU_SLTU;
          FN_SLL:          o_code = ALU_SLL;
          FN_SRL:          o_code = ALU_SRL;
          FN_SRA:          o_code = ALU_SRA;
`ifdef ALU_CTRL_MD_EN
          FN_MULT:         o_code = ALU_MULT;
          FN_DIV:          o_code = ALU_DIV;
`endif
          default:         o_illegal = 1'b1;
        endcase
      end
      OP_ADDI, OP_ADDIU, OP_LW, OP_SW: o_code = ALU_ADD;
      OP_BEQ, OP_BNE:                  o_code = ALU_SUB;
      OP_SLTI:                         o_code = ALU_SLT;
      OP_ANDI:                         o_code = ALU_AND;
      OP_ORI:                          o_code = ALU_OR;
      OP_XORI:                         o_code = ALU_XOR;
      OP_LUI:                          o_code = ALU_LUI;
      default:                         o_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_ctrl_pipe.sv
// Single-stage registered ALU control decode with valid/ready handshake. Defining
// ALU_CTRL_MD_EN adds MULT/DIV decode and an MD_LAT-cycle occupancy FSM.
module alu_ctrl_pipe
  import alu_ctrl_pkg::*;
#(
  parameter int unsigned ALUOPW = 4,
  parameter int unsigned MD_LAT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [5:0]        opcode,
  input  logic [5:0]        funct,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ALUOPW-1:0] aluop,
  output logic              illegal,
  output logic              md_busy
);

  logic              w_accept;
  logic [CODE_W-1:0] w_code;
  logic              w_illegal;
  logic              r_out_valid;
  logic [ALUOPW-1:0] r_aluop;
  logic              r_illegal;

  alu_ctrl_dec u_dec (
    .i_opcode  (opcode),
    .i_funct   (funct),
    .o_code    (w_code),
    .o_illegal (w_illegal)
  );

  // Stall while the output slot is held or the multi-cycle unit is occupied.
  assign in_ready = (!r_out_valid | out_ready) & !md_busy;
  assign w_accept = in_valid & in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_aluop     <= '0;
      r_illegal   <= 1'b0;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_aluop     <= ALUOPW'(w_code);
      r_illegal   <= w_illegal;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign aluop     = r_aluop;
  assign illegal   = r_illegal;

`ifdef ALU_CTRL_MD_EN
  md_state_t           r_state;
  md_state_t           w_state_nxt;
  logic [MD_CNT_W-1:0] r_cnt;
  logic [MD_CNT_W-1:0] w_cnt_nxt;
  logic                w_md_start;

  assign w_md_start = w_accept & !w_illegal & (MD_LAT != 0) &
                      ((w_code == ALU_MULT) | (w_code == ALU_DIV));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Counter holds remaining busy cycles including the current one.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      IDLE: begin
        if (w_md_start) begin
          w_state_nxt = BUSY;
          w_cnt_nxt   = MD_CNT_W'(MD_LAT);
        end
      end
      BUSY: begin
        w_cnt_nxt = r_cnt - MD_CNT_W'(1);
        if (r_cnt <= MD_CNT_W'(1)) begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  assign md_busy = (r_state == BUSY);
`else
  assign md_busy = 1'b0;
`endif

endmodule
